// File: rtl/uart_tx_arb_if.sv
// Requester-side and transmitter-side signals of the uart_tx arbiter, bundled so
// that the arbiter and its environment agree on widths through one parameter.
interface uart_tx_arb_if #(
    parameter int N_REQ = 4,
    parameter int GID_W = $clog2(N_REQ)
) ();
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   req_done;
    logic               tx_en;
    logic [7:0]         tx_data;
    logic               tx_done;
    logic               busy;
    logic [GID_W-1:0]   grant_id;
    logic               timeout_err;

    modport master (
        input  req_valid, req_data, tx_done,
        output req_ack, req_done, tx_en, tx_data, busy, grant_id, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_done,
        input  req_ack, req_done, tx_en, tx_data, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds one uart_tx from N_REQ byte producers, holds the
// granted byte for the whole frame and abandons frames whose tx_done never arrives.
module uart_tx_arb #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 128,
    parameter int GAP_CYC     = 0,
    parameter int GID_W       = $clog2(N_REQ)
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_arb_if.master bus
);
    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [GID_W-1:0] LAST_ID  = GID_W'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_e;

    state_e           state_q, state_d;
    logic [GID_W-1:0] ptr_q, ptr_d;
    logic [GID_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_en_q, tx_en_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic [N_REQ-1:0] req_ack_q, req_ack_d;
    logic [N_REQ-1:0] req_done_q, req_done_d;

    logic             found;
    logic [GID_W-1:0] pick;
    logic [GID_W-1:0] cand;
    logic [7:0]       sel_data;
    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] grant_oh;

    // Search ptr, ptr+1, ... (mod N_REQ); the first pending requester wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = GID_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        pick_oh  = '0;
        grant_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == GID_W'(i)) begin
                sel_data   = bus.req_data[8*i +: 8];
                pick_oh[i] = 1'b1;
            end
            if (grant_id_q == GID_W'(i)) grant_oh[i] = 1'b1;
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        tx_en_d       = 1'b0;
        req_ack_d     = '0;
        req_done_d    = '0;
        timeout_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_LAUNCH;
                    tx_data_d  = sel_data;
                    grant_id_d = pick;
                    ptr_d      = (pick == LAST_ID) ? '0 : pick + 1'b1;
                    tx_en_d    = 1'b1;
                    req_ack_d  = pick_oh;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // tx_done is tested first so it wins over a simultaneous timeout.
                if (bus.tx_done) begin
                    req_done_d = grant_oh;
                    cnt_d      = '0;
                    state_d    = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            cnt_q         <= '0;
            tx_data_q     <= '0;
            tx_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            req_ack_q     <= '0;
            req_done_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_en_q       <= tx_en_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            req_ack_q     <= req_ack_d;
            req_done_q    <= req_done_d;
        end
    end

    assign bus.tx_en       = tx_en_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.req_ack     = req_ack_q;
    assign bus.req_done    = req_done_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: a behavioural uart_tx (DIV=10) drives tx_done on the
// main instance; a second instance with GAP_CYC=3 is driven by hand.
module tb_uart_tx_arb;
    localparam int N_REQ = 4;
    localparam int DIV   = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks;
    int   n_pass;
    logic done_en;
    logic txd;

    logic [7:0] byte_tbl [4] = '{8'hC3, 8'h3C, 8'hA5, 8'h5A};

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } grant_t;

    grant_t     exp_grant_q[$];
    logic [1:0] exp_done_q[$];

    uart_tx_arb_if #(.N_REQ(N_REQ)) bus ();
    uart_tx_arb_if #(.N_REQ(N_REQ)) gbus ();

    uart_tx_arb #(.N_REQ(N_REQ), .TIMEOUT_CYC(128), .GAP_CYC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    uart_tx_arb #(.N_REQ(N_REQ), .TIMEOUT_CYC(128), .GAP_CYC(3)) dut_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (gbus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural uart_tx: start bit, 8 data bits LSB first read live from tx_data, stop bit.
    int   bitn;
    int   sub;
    logic active;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active      <= 1'b0;
            txd         <= 1'b1;
            bus.tx_done <= 1'b0;
            bitn        <= 0;
            sub         <= 0;
        end else begin
            bus.tx_done <= 1'b0;
            if (!active) begin
                if (bus.tx_en) begin
                    active <= 1'b1;
                    bitn   <= 0;
                    sub    <= 0;
                    txd    <= 1'b0;
                end
            end else if (sub == DIV - 1) begin
                sub <= 0;
                if (bitn == 9) begin
                    active      <= 1'b0;
                    txd         <= 1'b1;
                    bus.tx_done <= done_en;
                end else begin
                    bitn <= bitn + 1;
                    txd  <= (bitn < 8) ? bus.tx_data[bitn[2:0]] : 1'b1;
                end
            end else begin
                sub <= sub + 1;
            end
        end
    end

    function automatic logic [3:0] oh(input logic [1:0] i);
        oh = 4'b0001 << i;
    endfunction

    task automatic push_grant(input int id, input bit want_done);
        grant_t e;
        e.id   = 2'(id);
        e.data = byte_tbl[id];
        exp_grant_q.push_back(e);
        if (want_done) exp_done_q.push_back(2'(id));
    endtask

    task automatic sb_grant(input string tag, output int gcyc);
        grant_t e;
        int     k;
        int     stray;
        k     = 0;
        stray = 0;
        do begin
            @(negedge clk);
            k++;
            if (|bus.req_done) stray++;
        end while (bus.tx_en !== 1'b1 && k < 400);
        gcyc = cyc;
        e    = '0;
        if (exp_grant_q.size() > 0) e = exp_grant_q.pop_front();
        n_checks++;
        if (bus.tx_en !== 1'b1 || stray != 0 || bus.grant_id !== e.id ||
            bus.tx_data !== e.data || bus.req_ack !== oh(e.id))
            $display("FAIL %s: tx_en=%b id=%0d data=%h ack=%b stray_done=%0d, want tx_en=1 id=%0d data=%h ack=%b stray_done=0",
                     tag, bus.tx_en, bus.grant_id, bus.tx_data, bus.req_ack, stray, e.id, e.data, oh(e.id));
        else n_pass++;
    endtask

    task automatic sb_done(input string tag, output int dcyc);
        int         k;
        logic [1:0] id;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.req_done === 4'b0000 && k < 400);
        dcyc = cyc;
        id   = 2'd0;
        if (exp_done_q.size() > 0) id = exp_done_q.pop_front();
        n_checks++;
        if (bus.req_done !== oh(id))
            $display("FAIL %s: req_done=%b, want %b", tag, bus.req_done, oh(id));
        else n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.tx_en, bus.tx_data, bus.req_ack, bus.req_done, bus.busy, bus.grant_id, bus.timeout_err} !== '0)
            $display("FAIL reset_main: en=%b data=%h ack=%b done=%b busy=%b id=%0d to=%b, want all zero",
                     bus.tx_en, bus.tx_data, bus.req_ack, bus.req_done, bus.busy, bus.grant_id, bus.timeout_err);
        else n_pass++;
        n_checks++;
        if ({gbus.tx_en, gbus.tx_data, gbus.req_ack, gbus.req_done, gbus.busy, gbus.grant_id, gbus.timeout_err} !== '0)
            $display("FAIL reset_gap: en=%b data=%h busy=%b, want all zero", gbus.tx_en, gbus.tx_data, gbus.busy);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int         g;
        int         d;
        logic       bit_ok;
        logic       held;
        logic       late;
        logic [9:0] frame;
        frame = {1'b1, byte_tbl[2], 1'b0};
        held  = 1'b1;
        late  = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b0100;
        push_grant(2, 1'b1);
        sb_grant("single_grant", g);
        bus.req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            bit_ok = 1'b1;
            for (int j = 0; j < DIV; j++) begin
                @(negedge clk);
                if (k == 0 && j == 0) late = bus.tx_en | (|bus.req_ack);
                if (txd !== frame[k]) bit_ok = 1'b0;
                if (bus.tx_data !== byte_tbl[2]) held = 1'b0;
            end
            n_checks++;
            if (!bit_ok) $display("FAIL single_txd_bit%0d: line not %b for all %0d cycles", k, frame[k], DIV);
            else n_pass++;
        end
        n_checks++;
        if (late !== 1'b0) $display("FAIL single_pulse: tx_en/req_ack still high after one cycle (%b), want 0", late);
        else n_pass++;
        n_checks++;
        if (!held) $display("FAIL single_hold: tx_data changed during frame, want %h", byte_tbl[2]);
        else n_pass++;
        sb_done("single_done", d);
        n_checks++;
        if (d - g != 102 || bus.busy !== 1'b0)
            $display("FAIL single_done_time: done %0d cycles after launch busy=%b, want 102 and busy=0", d - g, bus.busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.req_done !== 4'b0000 || bus.busy !== 1'b0)
            $display("FAIL single_after: req_done=%b busy=%b, want 0000 0", bus.req_done, bus.busy);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int g;
        int d;
        do_reset();
        push_grant(0, 1'b1); push_grant(1, 1'b1); push_grant(2, 1'b1);
        push_grant(3, 1'b1); push_grant(0, 1'b1); push_grant(1, 1'b1);
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            sb_grant("rr_grant", g);
            if (n == 5) bus.req_valid = 4'b0101;
            sb_done("rr_done", d);
        end
    endtask

    task automatic test_fairness();
        int g;
        int d;
        push_grant(2, 1'b1); push_grant(0, 1'b1); push_grant(2, 1'b1); push_grant(0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            sb_grant("fair_grant", g);
            if (n == 3) bus.req_valid = '0;
            sb_done("fair_done", d);
        end
    endtask

    task automatic test_watchdog();
        int l;
        int to_cyc;
        int g;
        int d;
        int k;
        int stray;
        do_reset();
        done_en = 1'b0;
        bus.req_valid = 4'b0010;
        push_grant(1, 1'b0);
        sb_grant("wd_grant", l);
        bus.req_valid = 4'b1000;
        push_grant(3, 1'b1);
        k = 0;
        stray = 0;
        do begin
            @(negedge clk);
            k++;
            if (|bus.req_done) stray++;
        end while (bus.timeout_err !== 1'b1 && k < 400);
        to_cyc = cyc;
        n_checks++;
        if (bus.timeout_err !== 1'b1 || to_cyc - l != 129)
            $display("FAIL wd_time: timeout_err=%b at %0d cycles after launch, want 1 at 129", bus.timeout_err, to_cyc - l);
        else n_pass++;
        n_checks++;
        if (stray != 0 || bus.busy !== 1'b0)
            $display("FAIL wd_state: req_done pulses=%0d busy=%b, want 0 and 0", stray, bus.busy);
        else n_pass++;
        done_en = 1'b1;
        sb_grant("wd_next_grant", g);
        bus.req_valid = '0;
        n_checks++;
        if (g - to_cyc != 1) $display("FAIL wd_next_time: grant %0d cycles after timeout, want 1", g - to_cyc);
        else n_pass++;
        sb_done("wd_next_done", d);
    endtask

    task automatic test_gap();
        int k;
        int t;
        int extra;
        @(negedge clk);
        gbus.req_valid = 4'b0011;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (gbus.tx_en !== 1'b1 && k < 50);
        n_checks++;
        if (gbus.tx_en !== 1'b1 || gbus.grant_id !== 2'd0 || gbus.tx_data !== byte_tbl[0] || gbus.req_ack !== 4'b0001)
            $display("FAIL gap_first: en=%b id=%0d data=%h ack=%b, want 1 0 %h 0001",
                     gbus.tx_en, gbus.grant_id, gbus.tx_data, gbus.req_ack, byte_tbl[0]);
        else n_pass++;
        gbus.req_valid = 4'b0010;
        repeat (10) @(negedge clk);
        gbus.tx_done = 1'b1;
        t = cyc;
        @(negedge clk);
        gbus.tx_done = 1'b0;
        n_checks++;
        if (gbus.req_done !== 4'b0001 || gbus.busy !== 1'b1)
            $display("FAIL gap_done: req_done=%b busy=%b, want 0001 1", gbus.req_done, gbus.busy);
        else n_pass++;
        gbus.tx_done = 1'b1;
        @(negedge clk);
        gbus.tx_done = 1'b0;
        extra = 0;
        k = 0;
        while (gbus.tx_en !== 1'b1 && k < 50) begin
            if (|gbus.req_done) extra++;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (gbus.tx_en !== 1'b1 || cyc - t != 5 || extra != 0)
            $display("FAIL gap_spacing: tx_en=%b at %0d cycles after tx_done, extra done=%0d, want 1 at 5, 0",
                     gbus.tx_en, cyc - t, extra);
        else n_pass++;
        n_checks++;
        if (gbus.grant_id !== 2'd1 || gbus.tx_data !== byte_tbl[1] || gbus.req_ack !== 4'b0010)
            $display("FAIL gap_second: id=%0d data=%h ack=%b, want 1 %h 0010", gbus.grant_id, gbus.tx_data, gbus.req_ack, byte_tbl[1]);
        else n_pass++;
        gbus.req_valid = '0;
        repeat (5) @(negedge clk);
        gbus.tx_done = 1'b1;
        @(negedge clk);
        gbus.tx_done = 1'b0;
        n_checks++;
        if (gbus.req_done !== 4'b0010) $display("FAIL gap_second_done: req_done=%b, want 0010", gbus.req_done);
        else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int g;
        int d;
        int stray;
        do_reset();
        bus.req_valid = 4'b0010;
        push_grant(1, 1'b0);
        sb_grant("rst_grant", g);
        bus.req_valid = '0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.tx_en, bus.tx_data, bus.req_ack, bus.req_done, bus.busy, bus.grant_id, bus.timeout_err} !== '0)
            $display("FAIL rst_mid_values: en=%b data=%h ack=%b done=%b busy=%b id=%0d to=%b, want all zero",
                     bus.tx_en, bus.tx_data, bus.req_ack, bus.req_done, bus.busy, bus.grant_id, bus.timeout_err);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (|bus.req_done || bus.busy) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL rst_mid_quiet: %0d cycles with req_done/busy after reset, want 0", stray);
        else n_pass++;
        bus.req_valid = 4'b1111;
        push_grant(0, 1'b1);
        sb_grant("rst_first_grant", g);
        bus.req_valid = '0;
        sb_done("rst_first_done", d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish within 1 ms");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        done_en  = 1'b1;
        rst_n    = 1'b0;
        bus.req_valid  = '0;
        gbus.req_valid = '0;
        gbus.tx_done   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_data[8*i +: 8]  = byte_tbl[i];
            gbus.req_data[8*i +: 8] = byte_tbl[i];
        end
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_watchdog();
        test_gap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
